stopwatch_buttons: RTL and testbench

//  Control stage upstream of the two-digit BCD stopwatch counter/7-segment stage.

---
 rtl/stopwatch_buttons_pkg.sv | 23 ++
 rtl/stopwatch_buttons_if.sv | 31 +++
 rtl/stopwatch_buttons_debounce.sv | 65 ++++++
 rtl/stopwatch_buttons.sv | 101 ++++++++++
 tb/tb_stopwatch_buttons.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_buttons_pkg.sv
// Shared definitions for the stopwatch button control stage.
//   state_t            : controller state, also exported on STATE for LEDs
//   DEB_BITS_DEFAULT   : default debounce counter width (shared with the
//                        counter stage prescaler)
//   SYNC_STAGES_DEFAULT: default synchroniser depth per button
package stopwatch_buttons_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STOP = 2'b10
  } state_t;

  localparam int unsigned DEB_BITS_DEFAULT    = 15;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  // Cycles from a clean button edge (held steady) to the STATE/CE/CLR update.
  function automatic int unsigned press_latency(input int unsigned deb_bits,
                                                input int unsigned sync_stages);
    return sync_stages + (32'd1 << deb_bits) + 1;
  endfunction

endpackage

// File: rtl/stopwatch_buttons_if.sv
// Button / counter-stage signal group of the stopwatch control stage.
//   BTN_START : raw start/stop button, active high, asynchronous
//   BTN_CLEAR : raw clear button, active high, asynchronous
//   CE        : count enable to the counter stage
//   CLR       : clear to the counter stage, active high
//   STATE     : current controller state (00 IDLE, 01 RUN, 10 STOP)
// master drives the buttons and observes the outputs; slave is the
// control stage itself.
interface stopwatch_buttons_if;
  logic       BTN_START;
  logic       BTN_CLEAR;
  logic       CE;
  logic       CLR;
  logic [1:0] STATE;

  modport master (
    output BTN_START,
    output BTN_CLEAR,
    input  CE,
    input  CLR,
    input  STATE
  );

  modport slave (
    input  BTN_START,
    input  BTN_CLEAR,
    output CE,
    output CLR,
    output STATE
  );
endinterface

// File: rtl/stopwatch_buttons_debounce.sv
// button_debounce: synchronises one raw push-button, debounces it and emits
// a single-cycle press pulse on each accepted rising level.
//   C     : clock, posedge
//   CLR_N : asynchronous active-low reset
//   raw   : raw asynchronous button input, active high
//   press : registered one-cycle pulse when the debounced level rises
// The synchronised level must differ from the accepted level for
// 2**DEB_BITS consecutive cycles before it is accepted; any return to the
// accepted level restarts the window.
module button_debounce
  import stopwatch_buttons_pkg::*;
#(
  parameter int unsigned DEB_BITS    = DEB_BITS_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic C,
  input  logic CLR_N,
  input  logic raw,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DEB_BITS-1:0]    cnt_q;
  logic [DEB_BITS-1:0]    cnt_d;
  logic                   stable_q;
  logic                   stable_d;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync != stable_q) begin
      if (cnt_q == '1) begin
        stable_d = sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // press is taken from stable_d so the pulse lands on the same edge the
  // new level is accepted, rather than one cycle later.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press    <= stable_d & ~stable_q;
    end
  end

endmodule

// File: rtl/stopwatch_buttons.sv
// stopwatch_buttons: run/stop/clear controller ahead of the two-digit BCD
// stopwatch counter stage.
//   C     : clock, posedge
//   CLR_N : asynchronous active-low reset
//   io    : slave side of stopwatch_buttons_if
//           (BTN_START, BTN_CLEAR in; CE, CLR, STATE out)
// CE is high exactly while in RUN. CLR is held high during reset and
// pulses for one cycle whenever a clear press returns the controller to
// IDLE. Clear is ignored in RUN; a simultaneous start+clear is resolved as
// clear from IDLE/STOP and as start from RUN.
module stopwatch_buttons
  import stopwatch_buttons_pkg::*;
#(
  parameter int unsigned DEB_BITS    = DEB_BITS_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                C,
  input  logic                CLR_N,
  stopwatch_buttons_if.slave  io
);

  logic   start_p;
  logic   clear_p;
  state_t state_q;
  state_t state_d;
  logic   ce_q;
  logic   ce_d;
  logic   clr_q;
  logic   clr_d;

  button_debounce #(
    .DEB_BITS    (DEB_BITS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_deb_start (
    .C     (C),
    .CLR_N (CLR_N),
    .raw   (io.BTN_START),
    .press (start_p)
  );

  button_debounce #(
    .DEB_BITS    (DEB_BITS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_deb_clear (
    .C     (C),
    .CLR_N (CLR_N),
    .raw   (io.BTN_CLEAR),
    .press (clear_p)
  );

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_p) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end else if (start_p) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (start_p) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clear_p) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end else if (start_p) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Decoding from state_d keeps CE registered yet aligned with STATE.
    ce_d = (state_d == ST_RUN);
  end

  // CLR resets to 1 so the counter stage stays cleared during system reset.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= ST_IDLE;
      ce_q    <= 1'b0;
      clr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      ce_q    <= ce_d;
      clr_q   <= clr_d;
    end
  end

  assign io.STATE = state_q;
  assign io.CE    = ce_q;
  assign io.CLR   = clr_q;

endmodule

// File: tb/tb_stopwatch_buttons.sv
module tb_stopwatch_buttons;
  import stopwatch_buttons_pkg::*;

  localparam int unsigned DEB = 4;
  localparam int unsigned SYN = 2;
  localparam int unsigned L   = 19;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  val;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  int unsigned cyc = 0;
  int          n_run = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  exp_t        sbq[$];

  stopwatch_buttons_if io ();

  stopwatch_buttons #(
    .DEB_BITS    (DEB),
    .SYNC_STAGES (SYN)
  ) dut (
    .C     (clk),
    .CLR_N (clr_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_n(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int unsigned dly, input logic [1:0] st,
                          input logic ce, input logic clr);
    exp_t e;
    e.cyc = cyc + dly;
    e.val = {st, ce, clr};
    sbq.push_back(e);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_state"}, 32'(io.STATE), 32'(ST_IDLE));
    chk({tag, "_ce"},    32'(io.CE),    32'd0);
    chk({tag, "_clr"},   32'(io.CLR),   32'd1);
  endtask

  // Every output change must match the head of the scoreboard, at the
  // expected cycle; an expectation whose cycle passes unmatched is a miss.
  always @(negedge clk) begin
    logic [3:0] cur;
    logic [3:0] prev;
    exp_t       e;
    cur = {io.STATE, io.CE, io.CLR};
    if (!mon_en) begin
      prev = cur;
    end else if (cur != prev) begin
      if (sbq.size() == 0) begin
        chk("spurious", 32'(cur), 32'(prev));
      end else begin
        e = sbq.pop_front();
        chk("when", cyc, e.cyc);
        chk("outs", 32'(cur), 32'(e.val));
      end
      prev = cur;
    end else if (sbq.size() != 0 && cyc > sbq[0].cyc) begin
      e = sbq.pop_front();
      chk("missed", cyc, e.cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail + 1);
    $fatal(1);
  end

  initial begin
    io.BTN_START = 1'b0;
    io.BTN_CLEAR = 1'b0;

    // 1 reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_reset_outs("rst");
    end
    clr_n = 1'b1;
    push_exp(1, ST_IDLE, 1'b0, 1'b0);
    mon_en = 1'b1;
    wait_n(5);

    // 2 start / stop
    io.BTN_START = 1'b1;
    push_exp(L, ST_RUN, 1'b1, 1'b0);
    wait_n(30);
    io.BTN_START = 1'b0;
    wait_n(25);
    io.BTN_START = 1'b1;
    push_exp(L, ST_STOP, 1'b0, 1'b0);
    wait_n(30);
    io.BTN_START = 1'b0;
    wait_n(25);

    // 3 bounce, then steady; then a too-short pulse
    for (int i = 0; i < 8; i++) begin
      io.BTN_START = (i % 2 == 0);
      wait_n(5);
    end
    io.BTN_START = 1'b1;
    push_exp(L, ST_RUN, 1'b1, 1'b0);
    wait_n(25);
    io.BTN_START = 1'b0;
    wait_n(25);
    io.BTN_START = 1'b1;
    wait_n(10);
    io.BTN_START = 1'b0;
    wait_n(30);

    // 4 clear in RUN is ignored; clear in STOP pulses CLR
    io.BTN_CLEAR = 1'b1;
    wait_n(30);
    io.BTN_CLEAR = 1'b0;
    wait_n(25);
    chk("run_hold_state", 32'(io.STATE), 32'(ST_RUN));
    chk("run_hold_ce",    32'(io.CE),    32'd1);
    chk("run_hold_clr",   32'(io.CLR),   32'd0);
    io.BTN_START = 1'b1;
    push_exp(L, ST_STOP, 1'b0, 1'b0);
    wait_n(25);
    io.BTN_START = 1'b0;
    wait_n(25);
    io.BTN_CLEAR = 1'b1;
    push_exp(L,     ST_IDLE, 1'b0, 1'b1);
    push_exp(L + 1, ST_IDLE, 1'b0, 1'b0);
    wait_n(25);
    io.BTN_CLEAR = 1'b0;
    wait_n(25);

    // 5 simultaneous start+clear in STOP, then in RUN
    io.BTN_START = 1'b1;
    push_exp(L, ST_RUN, 1'b1, 1'b0);
    wait_n(25);
    io.BTN_START = 1'b0;
    wait_n(25);
    io.BTN_START = 1'b1;
    push_exp(L, ST_STOP, 1'b0, 1'b0);
    wait_n(25);
    io.BTN_START = 1'b0;
    wait_n(25);
    io.BTN_START = 1'b1;
    io.BTN_CLEAR = 1'b1;
    push_exp(L,     ST_IDLE, 1'b0, 1'b1);
    push_exp(L + 1, ST_IDLE, 1'b0, 1'b0);
    wait_n(25);
    io.BTN_START = 1'b0;
    io.BTN_CLEAR = 1'b0;
    wait_n(25);
    io.BTN_START = 1'b1;
    push_exp(L, ST_RUN, 1'b1, 1'b0);
    wait_n(25);
    io.BTN_START = 1'b0;
    wait_n(25);
    io.BTN_START = 1'b1;
    io.BTN_CLEAR = 1'b1;
    push_exp(L, ST_STOP, 1'b0, 1'b0);
    wait_n(25);
    io.BTN_START = 1'b0;
    io.BTN_CLEAR = 1'b0;
    wait_n(25);

    // 6 reset in the middle of a start window, button held across release
    chk("pre6_sb_empty", sbq.size(), 32'd0);
    io.BTN_START = 1'b1;
    wait_n(10);
    mon_en = 1'b0;
    clr_n  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_reset_outs("midrst");
    end
    clr_n = 1'b1;
    push_exp(1, ST_IDLE, 1'b0, 1'b0);
    push_exp(L, ST_RUN,  1'b1, 1'b0);
    mon_en = 1'b1;
    wait_n(30);
    io.BTN_START = 1'b0;
    wait_n(25);

    chk("sb_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
